// File: rtl/div16_seq.sv
// div16_seq -- iterative 16-bit restoring divider for the level4 ALU.
//
// Retires one quotient bit per clock, MSB first. Each step does a 17-bit
// trial subtraction. Operands come in over a valid/ready handshake and results
// leave over a second valid/ready handshake. Only one operation is in flight
// at a time.
//
// Optional build macro: DIV16_SIGNED_EN
//   undefined : unsigned operands, latency 16 (accept edge to out_valid)
//   defined   : two's-complement operands. A FIXUP state after the iterations
//               restores the signs, so latency is 17. The quotient truncates
//               toward zero and the remainder takes the sign of the dividend.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operand pair valid
//   in_ready  out  divider can accept operands (IDLE only)
//   in_a      in   dividend
//   in_b      in   divisor
//   out_valid out  result valid (DONE only)
//   out_ready in   consumer accepts result
//   out_quot  out  quotient
//   out_rem   out  remainder
//   out_dbz   out  divide-by-zero flag, qualified by out_valid
module div16_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quot,
   output logic [WIDTH-1:0] out_rem,
   output logic             out_dbz
);

   typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quot_q;   // dividend shift register, becomes the quotient
   logic [WIDTH-1:0] div_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dbz_q;
   logic [WIDTH:0]   trial;
   logic             last_iter;
   logic [WIDTH-1:0] a_core;
   logic [WIDTH-1:0] b_core;

   // Shifts the next dividend bit into the partial remainder and subtracts
   // the divisor. Bit WIDTH set means the result went negative.
   function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH-1:0] rem,
                                                input logic             nxt,
                                                input logic [WIDTH-1:0] b);
      trial_sub = {rem, nxt} - {1'b0, b};
   endfunction

`ifdef DIV16_SIGNED_EN
   logic sign_q_q;
   logic sign_r_q;

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                               input logic             s);
      neg_if = s ? (~v + 1'b1) : v;
   endfunction

   // The core works on magnitudes. The magnitude of -32768 is 0x8000 read as
   // unsigned. A zero divisor keeps the raw dividend so that the remainder
   // comes out as in_a unchanged.
   assign a_core = (in_b == '0) ? in_a : neg_if(in_a, in_a[WIDTH-1]);
   assign b_core = neg_if(in_b, in_b[WIDTH-1]);
`else
   assign a_core = in_a;
   assign b_core = in_b;
`endif

   assign trial     = trial_sub(rem_q, quot_q[WIDTH-1], div_q);
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = BUSY;
         end
         BUSY: begin
            if (last_iter) begin
`ifdef DIV16_SIGNED_EN
               state_d = FIXUP;
`else
               state_d = DONE;
`endif
            end
         end
         FIXUP: state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         quot_q <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
         dbz_q  <= 1'b0;
`ifdef DIV16_SIGNED_EN
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  quot_q <= a_core;
                  div_q  <= b_core;
                  rem_q  <= '0;
                  cnt_q  <= '0;
                  dbz_q  <= (in_b == '0);
`ifdef DIV16_SIGNED_EN
                  sign_q_q <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
                  sign_r_q <= in_a[WIDTH-1];
`endif
               end
            end
            BUSY: begin
               cnt_q <= cnt_q + 1'b1;
               if (!trial[WIDTH]) begin
                  rem_q  <= trial[WIDTH-1:0];
                  quot_q <= {quot_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q  <= {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
                  quot_q <= {quot_q[WIDTH-2:0], 1'b0};
               end
            end
`ifdef DIV16_SIGNED_EN
            FIXUP: begin
               if (!dbz_q) begin
                  quot_q <= neg_if(quot_q, sign_q_q);
                  rem_q  <= neg_if(rem_q, sign_r_q);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign out_quot = quot_q;
   assign out_rem  = rem_q;
   assign out_dbz  = dbz_q;

endmodule
